// File: rtl/exe_pkg.sv
// Shared definitions for the execute-stage result queue: default sizes,
// the occupancy state encoding and the pointer-width helper.
package exe_pkg;

  localparam int RESULT_WIDTH       = 32;
  localparam int RESULT_QUEUE_DEPTH = 4;

  // Occupancy state, derived from the entry count.
  typedef enum logic [1:0] {
    Q_EMPTY   = 2'd0,
    Q_PARTIAL = 2'd1,
    Q_FULL    = 2'd2
  } q_state_e;

  // Bits needed to address DEPTH entries; never less than one bit.
  function automatic int ptr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/result_queue_mem.sv
// Storage for the result queue: DEPTH x WIDTH register array with one
// synchronous write port, one asynchronous read port and a synchronous
// clear to zero on reset.
module result_queue_mem #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  parameter int PW    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [PW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write one entry per cycle; reset wipes every entry to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/exe_result_queue.sv
// In-order valid/ready buffer between the execute result datapath and
// write-back. Holds pointers, count, occupancy state and handshakes; the
// storage array lives in result_queue_mem.
// Optional feature: define EXE_RESULT_QUEUE_BYPASS_EN to let a result
// presented to an empty queue reach the output in the same cycle.
module exe_result_queue
  import exe_pkg::*;
#(
  parameter int DEPTH = RESULT_QUEUE_DEPTH,
  parameter int WIDTH = RESULT_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;
  q_state_e         state_q,  state_d;

  logic             stored_valid;
  logic             push;
  logic             pop;
  logic             mem_we;
  logic [WIDTH-1:0] mem_rdata;

  // Handshake readiness comes purely from registered state, so write-back
  // stalls never reach back into execute combinationally.
  assign in_ready     = (state_q != Q_FULL);
  assign stored_valid = (state_q != Q_EMPTY);

`ifdef EXE_RESULT_QUEUE_BYPASS_EN
  logic byp_act;
  logic byp_take;

  // A result arriving at an empty queue is shown immediately; if write-back
  // takes it, it never touches storage.
  assign byp_act   = (state_q == Q_EMPTY) & in_valid & ~flush & ~reset;
  assign byp_take  = byp_act & out_ready;
  assign out_valid = byp_act | stored_valid;
  assign out_data  = byp_act ? in_data : mem_rdata;
  assign push      = in_valid & in_ready & ~byp_take;
  assign pop       = stored_valid & out_ready;
`else
  assign out_valid = stored_valid;
  assign out_data  = mem_rdata;
  assign push      = in_valid & in_ready;
  assign pop       = stored_valid & out_ready;
`endif

  // A flushed push must not land in storage even though contents survive.
  assign mem_we = push & ~flush;

  // Next pointers, count and occupancy state; flush overrides push and pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    state_d  = state_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
    if (count_d == '0) begin
      state_d = Q_EMPTY;
    end else if (count_d == DEPTH_C) begin
      state_d = Q_FULL;
    end else begin
      state_d = Q_PARTIAL;
    end
  end

  // Register control state; reset returns the queue to empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= Q_EMPTY;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
    end
  end

  assign count = count_q;

  result_queue_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .PW    (PW)
  ) u_mem (
    .clk   (clk),
    .rst   (reset),
    .we    (mem_we),
    .waddr (wr_ptr_q),
    .wdata (in_data),
    .raddr (rd_ptr_q),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_exe_result_queue.sv
// Directed testbench for exe_result_queue (DEPTH=4, WIDTH=32). Expected
// values are written out by hand; the bypass build is selected with
// EXE_RESULT_QUEUE_BYPASS_EN.
module tb_exe_result_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [2:0]  count;

  int n_checks = 0;
  int n_fail   = 0;

  exe_result_queue #(.DEPTH(4), .WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs may then be changed safely.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;

    // Reset then idle
    for (int i = 0; i < 5; i++) begin
      #1;
      check("idle_out_valid", 32'(out_valid), 32'd0);
      check("idle_in_ready",  32'(in_ready),  32'd1);
      check("idle_count",     32'(count),     32'd0);
      check("idle_out_data",  out_data,       32'd0);
      tick();
    end

    // Fill with 1..4, write-back stalled
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_data = 32'(i);
      tick();
    end
    in_valid = 1'b0;
    #1;
    check("full_count",    32'(count),     32'd4);
    check("full_in_ready", 32'(in_ready),  32'd0);
    check("full_head",     out_data,       32'd1);
    in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
    tick();
    in_valid = 1'b0;
    #1;
    check("refused_count", 32'(count), 32'd4);

    // Drain in order
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      #1;
      check("drain_valid", 32'(out_valid), 32'd1);
      check("drain_data",  out_data,       32'(i));
      tick();
    end
    #1;
    check("drained_valid", 32'(out_valid), 32'd0);
    check("drained_count", 32'(count),     32'd0);
    out_ready = 1'b0;
    tick();

    // Streaming, 20 cycles
    in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      in_data = 32'h100 + 32'(k);
      #1;
`ifdef EXE_RESULT_QUEUE_BYPASS_EN
      check("stream_valid", 32'(out_valid), 32'd1);
      check("stream_data",  out_data,       32'h100 + 32'(k));
      check("stream_count", 32'(count),     32'd0);
`else
      if (k == 0) begin
        check("stream_valid0", 32'(out_valid), 32'd0);
      end else begin
        check("stream_valid", 32'(out_valid), 32'd1);
        check("stream_data",  out_data,       32'h100 + 32'(k - 1));
        check("stream_count", 32'(count),     32'd1);
      end
`endif
      tick();
    end
    in_valid = 1'b0;
    #1;
`ifndef EXE_RESULT_QUEUE_BYPASS_EN
    check("stream_last", out_data, 32'h113);
    tick();
    #1;
`endif
    check("stream_done_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b0;
    tick();

    // Full with simultaneous pop and push attempt
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 32'hA0 + 32'(i);
      tick();
    end
    in_data = 32'hBB; out_ready = 1'b1;
    #1;
    check("fullpp_in_ready", 32'(in_ready), 32'd0);
    check("fullpp_head",     out_data,      32'hA0);
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    check("fullpp_count", 32'(count), 32'd3);
    check("fullpp_next",  out_data,   32'hA1);

    // Flush at count 3 with a simultaneous push
    flush = 1'b1; in_valid = 1'b1; in_data = 32'hCAFE_F00D;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    check("flush_count",    32'(count),     32'd0);
    check("flush_valid",    32'(out_valid), 32'd0);
    check("flush_in_ready", 32'(in_ready),  32'd1);
    tick();
    #1;
    check("flush_idle_valid", 32'(out_valid), 32'd0);
    check("flush_idle_count", 32'(count),     32'd0);

    // Queue usable after flush; only the new value emerges
    in_valid = 1'b1; in_data = 32'h55;
    tick();
    in_valid = 1'b0;
    #1;
    check("postflush_count", 32'(count), 32'd1);
    check("postflush_data",  out_data,   32'h55);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    #1;
    check("postflush_empty", 32'(out_valid), 32'd0);

`ifdef EXE_RESULT_QUEUE_BYPASS_EN
    // Bypass on an empty queue
    in_valid = 1'b1; out_ready = 1'b1; in_data = 32'h1234_5678;
    #1;
    check("byp_valid", 32'(out_valid), 32'd1);
    check("byp_data",  out_data,       32'h1234_5678);
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    check("byp_count", 32'(count), 32'd0);
    // Flush kills the bypass
    flush = 1'b1; in_valid = 1'b1; in_data = 32'h77;
    #1;
    check("byp_flush_valid", 32'(out_valid), 32'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    check("byp_flush_count", 32'(count), 32'd0);
`endif

    // Reset mid-operation clears state and storage
    in_valid = 1'b1; in_data = 32'h99;
    tick();
    in_data = 32'h9A;
    tick();
    in_valid = 1'b0;
    #1;
    check("pre_reset_count", 32'(count), 32'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("reset_count",    32'(count),     32'd0);
    check("reset_valid",    32'(out_valid), 32'd0);
    check("reset_in_ready", 32'(in_ready),  32'd1);
    check("reset_data",     out_data,       32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
